// File: rtl/mmio_pkg.sv
// MMIO controller shared definitions.
// Register offsets, status bit layout and helpers.
package mmio_pkg;

  localparam logic [7:0] OFF_STATUS  = 8'h00;
  localparam logic [7:0] OFF_RXDATA  = 8'h04;
  localparam logic [7:0] OFF_TXDATA  = 8'h08;
  localparam logic [7:0] OFF_CYCLE   = 8'h10;
  localparam logic [7:0] OFF_INSTRET = 8'h14;
  localparam logic [7:0] OFF_CNTRST  = 8'h18;

  localparam int STAT_TX_RDY_BIT = 0;
  localparam int STAT_RX_FUL_BIT = 1;

  function automatic logic [31:0] status_word(
    input logic rx_full,
    input logic tx_full
  );
    logic [31:0] s;
    s = '0;
    s[STAT_RX_FUL_BIT] = rx_full;
    s[STAT_TX_RDY_BIT] = !tx_full;
    return s;
  endfunction

endpackage

// File: rtl/mmio_fifo.sv
// Synchronous FIFO with wrap-bit pointers.
// Push is refused when full, pop when empty.
module mmio_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         push_ok, pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mmio_ctrl.sv
// Memory-mapped UART, cycle and instret counters
// hanging off the CPU memory stage.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int          TX_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic        inst_retire,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        stall,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);

  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        rx_full_q, rx_full_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] ins_q, ins_d;

  logic        in_region;
  logic [7:0]  off;
  logic        wr_tx, push, pop;
  logic        tx_full, tx_empty;
  logic        rd_fire, cnt_clr;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign in_region = (addr[31:28] == MMIO_BASE[31:28]);
  assign off       = addr[7:0];
  assign unused_bits = ^{addr[27:8], wdata[31:8]};

  // A full FIFO stalls the store; the push lands once a slot frees.
  assign wr_tx   = we && in_region && (off == OFF_TXDATA);
  assign stall   = wr_tx && tx_full;
  assign push    = wr_tx && !tx_full;
  assign pop     = uart_tx_valid && uart_tx_ready;
  assign rd_fire = re && in_region && !stall;
  assign cnt_clr = we && in_region && (off == OFF_CNTRST);

  assign uart_tx_valid = !tx_empty;
  assign uart_rx_ready = !rx_full_q;
  assign rdata         = rdata_q;
  assign rvalid        = rvalid_q;

  mmio_fifo #(
    .W     (8),
    .DEPTH (TX_DEPTH)
  ) u_txq (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata[7:0]),
    .pop   (pop),
    .rdata (uart_tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      off == OFF_STATUS:  rd_val = status_word(rx_full_q, tx_full);
      off == OFF_RXDATA:  rd_val = rx_full_q ? {24'b0, rx_byte_q} : '0;
      off == OFF_CYCLE:   rd_val = cyc_q;
      off == OFF_INSTRET: rd_val = ins_q;
      default:            rd_val = '0;
    endcase
  end

  always_comb begin
    rdata_d   = rd_fire ? rd_val : rdata_q;
    rvalid_d  = rd_fire;
    rx_full_d = rx_full_q;
    rx_byte_d = rx_byte_q;
    if (rd_fire && (off == OFF_RXDATA) && rx_full_q) rx_full_d = 1'b0;
    if (uart_rx_valid && uart_rx_ready) begin
      rx_full_d = 1'b1;
      rx_byte_d = uart_rx_data;
    end
    cyc_d = cnt_clr ? '0 : cyc_q + 32'd1;
    ins_d = cnt_clr ? '0 : ins_q + {31'b0, inst_retire};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      rx_full_q <= 1'b0;
      rx_byte_q <= '0;
      cyc_q     <= '0;
      ins_q     <= '0;
    end else begin
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      rx_full_q <= rx_full_d;
      rx_byte_q <= rx_byte_d;
      cyc_q     <= cyc_d;
      ins_q     <= ins_d;
    end
  end

endmodule

// File: doc/mmio_ctrl.md
MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 Parameter: TX_DEPTH, default 4, TX FIFO entries (power of two, >=2).
REQ-002 Parameter: MMIO_BASE, default 32'h8000_0000, MMIO region base (region = addr[31:28]==MMIO_BASE[31:28]).
REQ-003 Ports, one per line, shall be:
  clk  in  1  sole clock, rising edge
  rst  in  1  reset, asynchronous, active-low
  addr  in  32  CPU memory-stage byte address
  re  in  1  CPU load strobe
  we  in  1  CPU store strobe
  wdata  in  32  store data, [7:0] used
  inst_retire  in  1  one instruction retired this cycle
  rdata  out  32  registered load data
  rvalid  out  1  rdata valid, one-cycle pulse
  stall  out  1  hold CPU memory stage
  uart_rx_data  in  8  received byte
  uart_rx_valid  in  1  received byte valid
  uart_rx_ready  out  1  controller accepts byte
  uart_tx_data  out  8  byte to transmit
  uart_tx_valid  out  1  transmit byte valid
  uart_tx_ready  in  1  transmitter accepts byte

Function
REQ-004 Decode offsets (addr[7:0]): 0x00 status RO, 0x04 RX data RO, 0x08 TX data WO, 0x10 cycle counter RO, 0x14 instret counter RO, 0x18 counter reset WO.
REQ-005 Status read shall return {30'b0, rx_full, !tx_full}.
REQ-006 Loads: re & in-region & !stall in cycle N -> rdata valid with rvalid=1 in cycle N+1; value sampled in cycle N.
REQ-007 Unmapped or write-only offset reads return 0; unmapped writes and writes to RO offsets are ignored; out-of-region accesses ignored, rvalid stays 0.
REQ-008 RX holding register: capture uart_rx_data when uart_rx_valid & uart_rx_ready; uart_rx_ready = !rx_full.
REQ-009 Read of 0x04 when rx_full returns {24'b0, byte} and clears rx_full at the same edge; when empty returns 0, no state change.
REQ-010 TX FIFO: write of 0x08 with FIFO not full pushes wdata[7:0]; uart_tx_data/uart_tx_valid driven from FIFO head; pop on uart_tx_valid & uart_tx_ready.
REQ-011 Write to 0x08 with FIFO full: stall=1 combinationally until an entry frees; no pass-through, even if a pop occurs in the same cycle (push occurs next cycle).
REQ-012 Push and pop in same cycle with FIFO not full: occupancy unchanged, order preserved.
REQ-013 Cycle counter: 32-bit, +1 every cycle, wraps 0xFFFF_FFFF -> 0.
REQ-014 Instret counter: 32-bit, +1 on cycles with inst_retire=1, wraps.
REQ-015 Write to 0x18 in cycle N: both counters read 0 in cycle N+1; reset wins over simultaneous increment.
REQ-016 stall shall be 0 for all accesses except REQ-011.

Reset
REQ-017 On rst=0, asynchronously: rdata=0, rvalid=0, rx_full=0, FIFO empty (uart_tx_valid=0), both counters=0; uart_rx_ready=1 after release.
REQ-018 Reset mid-operation discards FIFO contents and held RX byte; no partial byte emitted.

Structure
REQ-019 Offset constants and status bit positions shall live in shared package mmio_pkg.
REQ-020 TX FIFO shall be sub-module mmio_fifo (parameterised width/depth, full/empty outputs).

Verification
REQ-021 Reset, then read 0x00 -> rdata=32'h1 one cycle later, rvalid=1 one cycle.
REQ-022 uart_rx_data=8'h5A with uart_rx_valid=1 -> status=32'h3; read 0x04 -> 32'h5A, next status=32'h1, uart_rx_ready=1.
REQ-023 uart_tx_ready=0, five writes to 0x08 (0x41..0x45) -> first four accepted, fifth stalls; raise uart_tx_ready -> bytes 0x41..0x45 emitted in order, stall drops.
REQ-024 Write 0x18, hold inst_retire=1 for 10 cycles, read 0x14 -> 10; read 0x10 one cycle later -> 11.
REQ-025 Force cycle counter to 0xFFFF_FFFF -> next cycle reads 0.
REQ-026 Assert rst=0 with FIFO holding 3 bytes -> uart_tx_valid=0 immediately, status after release =32'h1.
